// File: rtl/axi_stream_packetizer_pkg.sv
// Shared types and helpers for the AXI Stream packetizer: FSM state, default
// channel/request/response structs and the effective packet length function.
package axi_stream_packetizer_pkg;

  localparam int unsigned TDataWidth = 32;
  localparam int unsigned TIdWidth   = 4;
  localparam int unsigned TDestWidth = 4;
  localparam int unsigned TUserWidth = 4;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  typedef struct packed {
    logic [TDataWidth-1:0]   tdata;
    logic [TDataWidth/8-1:0] tstrb;
    logic [TDataWidth/8-1:0] tkeep;
    logic                    tlast;
    logic [TIdWidth-1:0]     tid;
    logic [TDestWidth-1:0]   tdest;
    logic [TUserWidth-1:0]   tuser;
  } chan_t;

  typedef struct packed {
    chan_t t;
    logic  tvalid;
  } req_t;

  typedef struct packed {
    logic tready;
  } rsp_t;

  // A programmed length of zero encodes the maximum packet, 2^len_width beats.
  function automatic logic [31:0] effective_len(input logic [31:0] len,
                                                input int unsigned len_width);
    return (len == 32'd0) ? (32'd1 << len_width) : len;
  endfunction

endpackage

// File: rtl/axi_stream_packetizer_ctrl.sv
// Packet framing control: FSM, beat counter, per-packet tid/tdest capture and,
// when AXI_STREAM_PACKETIZER_SEQ_EN is defined, the packet sequence counter.
module axi_stream_packetizer_ctrl
  import axi_stream_packetizer_pkg::*;
#(
  parameter int unsigned LenWidth  = 8,
  parameter int unsigned SeqWidth  = 8,
  parameter int unsigned IdWidth   = TIdWidth,
  parameter int unsigned DestWidth = TDestWidth,
  parameter int unsigned UserWidth = TUserWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 flush_i,
  input  logic [LenWidth-1:0]  pkt_len_i,
  input  logic [IdWidth-1:0]   tid_i,
  input  logic [DestWidth-1:0] tdest_i,
  output logic                 tlast_o,
  output logic [IdWidth-1:0]   tid_o,
  output logic [DestWidth-1:0] tdest_o,
  output logic [UserWidth-1:0] tuser_o,
  output logic                 busy_o
);

  localparam int unsigned CntWidth = LenWidth + 1;

  state_e                state;
  logic [CntWidth-1:0]   cnt;
  logic [CntWidth-1:0]   len_cap;
  logic [CntWidth-1:0]   len_eff;
  logic [IdWidth-1:0]    tid_cap;
  logic [DestWidth-1:0]  tdest_cap;

  assign len_eff = CntWidth'(effective_len(32'(pkt_len_i), LenWidth));
  assign busy_o  = (state == ACTIVE);

  // The first beat of a packet takes its framing straight from the inputs, so
  // a packet can start in the cycle right after the previous one ended.
  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    tlast_o = flush_i;
    tid_o   = tid_cap;
    tdest_o = tdest_cap;
    if (state == IDLE) begin
      tlast_o = flush_i | (len_eff == CntWidth'(1));
      tid_o   = tid_i;
      tdest_o = tdest_i;
    end else begin
      tlast_o = flush_i | (cnt == len_cap - CntWidth'(1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      len_cap   <= '0;
      tid_cap   <= '0;
      tdest_cap <= '0;
    end else if (load_i) begin
      case (state)
        IDLE: begin
          len_cap   <= len_eff;
          tid_cap   <= tid_i;
          tdest_cap <= tdest_i;
          cnt       <= CntWidth'(1);
          if (!tlast_o) begin
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (tlast_o) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CntWidth'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_STREAM_PACKETIZER_SEQ_EN
  logic [SeqWidth-1:0] seq;

  // The tlast beat still carries the old number; the increment lands with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seq <= '0;
    end else if (load_i && tlast_o) begin
      seq <= seq + 1'b1;
    end
  end

  assign tuser_o = UserWidth'(seq);
`else
  assign tuser_o = '0;
`endif

endmodule

// File: rtl/axi_stream_packetizer.sv
// AXI4-Stream packetizer top: frames a valid/ready word stream into packets on
// a fully registered Tx port. Optional sequence numbering in tuser is enabled
// with the AXI_STREAM_PACKETIZER_SEQ_EN macro.
module axi_stream_packetizer
  import axi_stream_packetizer_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LenWidth  = 8,
  parameter int unsigned SeqWidth  = 8,
  parameter int unsigned IdWidth   = TIdWidth,
  parameter int unsigned DestWidth = TDestWidth,
  parameter int unsigned UserWidth = TUserWidth,
  parameter type s_chan_t          = chan_t,
  parameter type axi_stream_req_t  = req_t,
  parameter type axi_stream_rsp_t  = rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [DataWidth-1:0] data_i,
  input  logic [LenWidth-1:0]  pkt_len_i,
  input  logic [IdWidth-1:0]   tid_i,
  input  logic [DestWidth-1:0] tdest_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output axi_stream_req_t      tx_req_o,
  input  axi_stream_rsp_t      tx_rsp_i
);

  logic                 in_fire;
  logic                 beat_last;
  logic [IdWidth-1:0]   beat_tid;
  logic [DestWidth-1:0] beat_tdest;
  logic [UserWidth-1:0] beat_tuser;
  s_chan_t              beat;

  // The output register can take a new word whenever it is empty or draining.
  assign data_ready_o = !tx_req_o.tvalid | tx_rsp_i.tready;
  assign in_fire      = data_valid_i & data_ready_o;

  axi_stream_packetizer_ctrl #(
    .LenWidth  (LenWidth),
    .SeqWidth  (SeqWidth),
    .IdWidth   (IdWidth),
    .DestWidth (DestWidth),
    .UserWidth (UserWidth)
  ) u_ctrl (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (in_fire),
    .flush_i   (flush_i),
    .pkt_len_i (pkt_len_i),
    .tid_i     (tid_i),
    .tdest_i   (tdest_i),
    .tlast_o   (beat_last),
    .tid_o     (beat_tid),
    .tdest_o   (beat_tdest),
    .tuser_o   (beat_tuser),
    .busy_o    (busy_o)
  );

  always_comb begin
    beat       = '0;
    beat.tdata = data_i;
    beat.tstrb = '1;
    beat.tkeep = '1;
    beat.tlast = beat_last;
    beat.tid   = beat_tid;
    beat.tdest = beat_tdest;
    beat.tuser = beat_tuser;
  end

  // A stalled beat stays untouched until the sink takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_req_o <= '0;
    end else if (in_fire) begin
      tx_req_o.t      <= beat;
      tx_req_o.tvalid <= 1'b1;
    end else if (tx_rsp_i.tready) begin
      tx_req_o.tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_stream_packetizer.sv
// Self-checking bench for axi_stream_packetizer against a queue-based packet
// model; expects tuser sequence numbers when AXI_STREAM_PACKETIZER_SEQ_EN is set.
module tb_axi_stream_packetizer;
  import axi_stream_packetizer_pkg::*;

  localparam int unsigned LenW = 3;
  localparam int unsigned SeqW = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [31:0] data_i;
  logic [2:0]  pkt_len_i;
  logic [3:0]  tid_i;
  logic [3:0]  tdest_i;
  logic        flush_i;
  logic        busy_o;
  req_t        tx_req_o;
  rsp_t        tx_rsp_i;

  axi_stream_packetizer #(
    .DataWidth (32),
    .LenWidth  (LenW),
    .SeqWidth  (SeqW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_i       (data_i),
    .pkt_len_i    (pkt_len_i),
    .tid_i        (tid_i),
    .tdest_i      (tdest_i),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .tx_req_o     (tx_req_o),
    .tx_rsp_i     (tx_rsp_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  tid;
    logic [3:0]  tdest;
    logic [3:0]  tuser;
  } beat_t;

  beat_t exp_q[$];
  int    checks    = 0;
  int    failures  = 0;
  int    accepted  = 0;
  int    delivered = 0;
  int    lasts     = 0;

  // Packet model: position inside the open packet, its length and framing.
  int          pos      = 0;
  int          pkt_beats = 0;
  logic [3:0]  pkt_tid;
  logic [3:0]  pkt_tdest;
  int          seq      = 0;

  logic hold_pending = 1'b0;
  req_t held;

  task automatic model_reset();
    exp_q.delete();
    pos          = 0;
    seq          = 0;
    hold_pending = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, sample 1 ns later,
  // score any output handshake and feed any input handshake to the model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic [2:0] len,
                       input logic fl, input logic [3:0] id, input logic [3:0] de,
                       input logic rdy);
    beat_t e;
    @(negedge clk_i);
    data_valid_i    = v;
    data_i          = d;
    pkt_len_i       = len;
    flush_i         = fl;
    tid_i           = id;
    tdest_i         = de;
    tx_rsp_i.tready = rdy;
    #1;
    checks++;
    if (busy_o !== (pos != 0)) begin
      failures++;
      $display("FAIL busy: got %b expected %b", busy_o, pos != 0);
    end
    checks++;
    if (data_ready_o !== (!tx_req_o.tvalid || rdy)) begin
      failures++;
      $display("FAIL data_ready: got %b expected %b", data_ready_o, !tx_req_o.tvalid || rdy);
    end
    checks++;
    if (tx_req_o.tvalid !== (exp_q.size() != 0)) begin
      failures++;
      $display("FAIL tvalid: got %b expected %b (pending beats %0d)",
               tx_req_o.tvalid, exp_q.size() != 0, exp_q.size());
    end
    if (hold_pending) begin
      checks++;
      if (tx_req_o !== held) begin
        failures++;
        $display("FAIL stall_hold: got %h expected %h", tx_req_o, held);
      end
    end
    if (tx_req_o.tvalid === 1'b1 && rdy) begin
      delivered++;
      if (tx_req_o.t.tlast === 1'b1) lasts++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (tx_req_o.t.tdata !== e.data || tx_req_o.t.tlast !== e.last ||
            tx_req_o.t.tid !== e.tid || tx_req_o.t.tdest !== e.tdest ||
            tx_req_o.t.tuser !== e.tuser || tx_req_o.t.tkeep !== 4'hf ||
            tx_req_o.t.tstrb !== 4'hf) begin
          failures++;
          $display("FAIL beat: got data=%h last=%b tid=%h tdest=%h tuser=%h keep=%h strb=%h, expected data=%h last=%b tid=%h tdest=%h tuser=%h keep=f strb=f",
                   tx_req_o.t.tdata, tx_req_o.t.tlast, tx_req_o.t.tid, tx_req_o.t.tdest,
                   tx_req_o.t.tuser, tx_req_o.t.tkeep, tx_req_o.t.tstrb,
                   e.data, e.last, e.tid, e.tdest, e.tuser);
        end
      end
    end
    hold_pending = (tx_req_o.tvalid === 1'b1) && !rdy;
    held         = tx_req_o;
    if (v && data_ready_o === 1'b1) begin
      accepted++;
      if (pos == 0) begin
        pkt_beats = (len == 3'd0) ? (1 << LenW) : int'(len);
        pkt_tid   = id;
        pkt_tdest = de;
      end
      pos++;
      e.data  = d;
      e.last  = (pos == pkt_beats) || fl;
      e.tid   = pkt_tid;
      e.tdest = pkt_tdest;
`ifdef AXI_STREAM_PACKETIZER_SEQ_EN
      e.tuser = 4'(seq);
`else
      e.tuser = 4'd0;
`endif
      exp_q.push_back(e);
      if (e.last) begin
        pos = 0;
        seq = (seq + 1) % (1 << SeqW);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || tx_req_o.tvalid === 1'b1) && n < 30) begin
      cycle(1'b0, 32'h0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: pending beats %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if (tx_req_o !== '0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got req=%h busy=%b expected req=0 busy=0", tx_req_o, busy_o);
    end
    checks++;
    if (data_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", data_ready_o);
    end
  endtask

  task automatic test_basic();
    int a0 = accepted, d0 = delivered, l0 = lasts;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 32'hA000_0000 + i, 3'd4, 1'b0, 4'h6, 4'h9, 1'b1);
    cycle(1'b0, 32'h0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b1);
    checks++;
    if (accepted - a0 != 8 || delivered - d0 != 8) begin
      failures++;
      $display("FAIL basic_throughput: got accepted=%0d delivered=%0d expected 8/8",
               accepted - a0, delivered - d0);
    end
    checks++;
    if (lasts - l0 != 2) begin
      failures++;
      $display("FAIL basic_tlast_count: got %0d expected 2", lasts - l0);
    end
  endtask

  task automatic test_flush();
    int l0 = lasts;
    cycle(1'b0, 32'h0, 3'd4, 1'b1, 4'h1, 4'h2, 1'b1);
    cycle(1'b1, 32'hB000_0001, 3'd4, 1'b0, 4'h1, 4'h2, 1'b1);
    cycle(1'b0, 32'h0, 3'd4, 1'b1, 4'h7, 4'h7, 1'b1);
    cycle(1'b1, 32'hB000_0002, 3'd4, 1'b1, 4'h1, 4'h2, 1'b1);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'hB100_0000 + i, 3'd4, (i == 3), 4'h3, 4'h5, 1'b1);
    drain();
    checks++;
    if (lasts - l0 != 2) begin
      failures++;
      $display("FAIL flush_tlast_count: got %0d expected 2", lasts - l0);
    end
  endtask

  task automatic test_len_edges();
    int l0 = lasts;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'hC000_0000 + i, 3'd1, 1'b0, 4'(i), 4'(i + 1), 1'b1);
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 32'hC100_0000 + i, 3'd0, 1'b0, 4'hA, 4'hB, 1'b1);
    drain();
    checks++;
    if (lasts - l0 != 5) begin
      failures++;
      $display("FAIL len_edges_tlast_count: got %0d expected 5", lasts - l0);
    end
  endtask

  task automatic test_stall();
    int a0, d0, n;
    cycle(1'b1, 32'hD000_0000, 3'd2, 1'b0, 4'h4, 4'h4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hD000_0001, 3'd2, 1'b0, 4'h4, 4'h4, 1'b0);
      checks++;
      if (data_ready_o !== 1'b0 || tx_req_o.tvalid !== 1'b1) begin
        failures++;
        $display("FAIL stall_ready: got ready=%b tvalid=%b expected 0/1",
                 data_ready_o, tx_req_o.tvalid);
      end
    end
    drain();
    a0 = accepted;
    d0 = delivered;
    n  = 0;
    while (accepted - a0 < 20 && n < 400) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 5) == 0), 4'($urandom), 4'($urandom),
            1'($urandom_range(0, 2) != 0));
      n++;
    end
    drain();
    checks++;
    if (accepted - a0 != 20 || delivered - d0 != accepted - a0) begin
      failures++;
      $display("FAIL random_stall_count: got accepted=%0d delivered=%0d expected 20/20",
               accepted - a0, delivered - d0);
    end
    // Close any packet left open so later tests start from IDLE.
    if (pos != 0) begin
      cycle(1'b1, 32'hD0FF_0000, 3'd0, 1'b1, 4'h0, 4'h0, 1'b1);
      drain();
    end
  endtask

  task automatic test_mid_reset();
    int d0, l0;
    cycle(1'b1, 32'hE000_0001, 3'd4, 1'b0, 4'h8, 4'h1, 1'b1);
    cycle(1'b1, 32'hE000_0002, 3'd4, 1'b0, 4'h8, 4'h1, 1'b1);
    @(negedge clk_i);
    data_valid_i = 1'b0;
    rst_ni       = 1'b0;
    #1;
    checks++;
    if (tx_req_o.tvalid !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got tvalid=%b busy=%b expected 0/0", tx_req_o.tvalid, busy_o);
    end
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    d0 = delivered;
    l0 = lasts;
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'hE100_0000 + i, 3'd4, 1'b0, 4'hC, 4'hD, 1'b1);
    drain();
    checks++;
    if (delivered - d0 != 4 || lasts - l0 != 1) begin
      failures++;
      $display("FAIL post_reset_packet: got beats=%0d lasts=%0d expected 4/1",
               delivered - d0, lasts - l0);
    end
  endtask

  task automatic test_seq();
    int l0 = lasts;
    for (int p = 0; p < 5; p++) begin
      int len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++)
        cycle(1'b1, $urandom, 3'(len), 1'b0, 4'(p), 4'(p), 1'b1);
    end
    drain();
    checks++;
    if (lasts - l0 != 5) begin
      failures++;
      $display("FAIL seq_packets: got %0d expected 5", lasts - l0);
    end
  endtask

  initial begin
    rst_ni          = 1'b0;
    data_valid_i    = 1'b0;
    data_i          = '0;
    pkt_len_i       = '0;
    tid_i           = '0;
    tdest_i         = '0;
    flush_i         = 1'b0;
    tx_rsp_i.tready = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    test_reset();
    rst_ni = 1'b1;
    test_basic();
    test_flush();
    test_len_edges();
    test_stall();
    test_mid_reset();
    test_seq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_stream_packetizer.md
Name: axi_stream_packetizer

Overview:
- AXI4-Stream transmitter: converts a plain valid/ready word stream into framed AXI Stream packets on a struct-typed Tx port.
- Asserts tlast by beat count or on an explicit flush; tid/tdest are held per packet; tkeep/tstrb are all ones.
- Sits at the producer end of a stream link, upstream of cuts, FIFOs and muxes.
- Output is fully registered: no combinational path from inputs to tx_req_o.

Parameters:
- DataWidth, 32, tdata width in bits; must be a multiple of 8.
- LenWidth, 8, width of pkt_len_i; packets are 1..2^LenWidth beats.
- SeqWidth, 8, packet sequence counter width (used only with the optional feature).
- s_chan_t, logic, AXI Stream channel struct (t, tdata, tstrb, tkeep, tlast, tid, tdest, tuser).
- axi_stream_req_t, logic, request struct (t, tvalid).
- axi_stream_rsp_t, logic, response struct (tready).

Ports:
- clk_i  in  1  clock; the block uses one clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_valid_i  in  1  input word valid.
- data_ready_o  out  1  input word ready.
- data_i  in  DataWidth  input word.
- pkt_len_i  in  LenWidth  beats per packet; 0 means 2^LenWidth; sampled on the first beat of a packet.
- tid_i  in  width of s_chan_t.tid  packet id; sampled on the first beat.
- tdest_i  in  width of s_chan_t.tdest  packet destination; sampled on the first beat.
- flush_i  in  1  qualified by the input handshake; forces the current beat to be the last beat.
- busy_o  out  1  high while a packet is open (state ACTIVE).
- tx_req_o  out  axi_stream_req_t  Tx request.
- tx_rsp_i  in  axi_stream_rsp_t  Tx response.

Behaviour:
- Reset values: tx_req_o.tvalid=0; tx_req_o.t all zero; busy_o=0; beat counter=0; state IDLE.
- Input accept: in = data_valid_i & data_ready_o.
- data_ready_o = !out_valid | tx_rsp_i.tready. This is a combinational path from tready; it gives full throughput of 1 beat/cycle.
- Latency: a word accepted in cycle N is presented on tx_req_o in cycle N+1.
- Output register rules:
  - Loads on in.
  - Clears tvalid on accept without in.
  - Holds t and tvalid stable while tvalid & !tready. This is the AXI rule; tvalid never drops without a handshake.
- Per-beat output fields: tkeep and tstrb all ones. tid/tdest come from the packet-start sample; the first beat uses tid_i/tdest_i directly.
- Effective length L = (pkt_len_i==0) ? 2^LenWidth : pkt_len_i. Compute at LenWidth+1 bits.
- FSM, state IDLE:
  - On in: capture L, tid_i, tdest_i, set cnt=1.
  - tlast = (L==1) | flush_i.
  - If tlast, stay IDLE; else go ACTIVE.
- FSM, state ACTIVE:
  - On in: tlast = (cnt==L_cap-1) | flush_i.
  - If tlast, go IDLE and set cnt=0; else cnt++.
  - pkt_len_i, tid_i and tdest_i are ignored in ACTIVE.
- flush_i without a handshake has no effect.
- flush_i on the exact length-final beat yields a single tlast, not a double.
- Back-to-back packets: the first beat of the next packet is accepted in the cycle after the last beat, with no bubble.
- busy_o = (state==ACTIVE).
- Asynchronous reset mid-packet:
  - All state clears and the output beat is dropped (tvalid=0).
  - The next accepted word starts a new packet.
- tuser = 0 unless the optional feature is enabled.

Optional Feature:
- Macro: AXI_STREAM_PACKETIZER_SEQ_EN.
- Defined:
  - A SeqWidth-bit packet sequence counter, reset 0, increments when a tlast beat is loaded into the output register.
  - It wraps from 2^SeqWidth-1 to 0.
  - Every beat carries the sequence number of its packet in tuser, zero-extended or truncated to the tuser width.
- Not defined: no counter; tuser=0; SeqWidth unused.

Decomposition:
- Package axi_stream_packetizer_pkg:
  - state enum (IDLE, ACTIVE);
  - function computing effective length from pkt_len_i.
- Channel/req/rsp types come from the existing AXI Stream typedef macros at the instantiation site.
- One natural sub-module: axi_stream_packetizer_ctrl. It holds the FSM, beat counter, captured tid/tdest and optional sequence counter, and outputs tlast/tid/tdest/tuser for the load.
- The top holds the output register and handshake.

Test Plan:
1. pkt_len_i=4, 8 words, tready=1 -> tlast on beats 4 and 8; busy_o high from beat 1 until beat 4 accepted; 1 beat/cycle; 1-cycle latency.
2. pkt_len_i=4, flush_i with word 2 -> tlast on beat 2; next word starts a new packet and captures new tid=3/tdest=5.
3. pkt_len_i=1 and pkt_len_i=0 (LenWidth=2) -> every beat tlast for len 1; tlast every 4th beat for len 0.
4. tready low for 3 cycles with tvalid high -> tx_req_o stable; data_ready_o=0; no words lost or duplicated over 20 random-stall beats.
5. Reset asserted mid-packet (beat 2 of 4) -> tvalid=0 and busy_o=0 immediately; next packet has 4 beats with correct tlast.
6. AXI_STREAM_PACKETIZER_SEQ_EN, SeqWidth=2, 5 packets -> tuser sequence 0,1,2,3,0 constant within each packet.
